// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - four-digit multiplexed seven-segment scan driver with guard interval and frame-synchronous loads
// Optional build macro: SSEG_LEADING_ZERO_BLANK_EN (leading-zero suppression on digits 3..1)
module sseg_scan_driver #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic        M_CLOCK,
    input  logic        RESET,
    input  logic [15:0] DATA,
    input  logic [3:0]  DP_IN,
    input  logic [3:0]  BLANK,
    input  logic        LOAD,
    output logic [3:0]  IO_SSEGD,
    output logic [7:0]  IO_SSEG,
    output logic        IO_SSEG_COL,
    output logic        FRAME_DONE
);

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [15:0] CNT_LAST   = 16'(DIGIT_CYCLES - 1);
    localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [1:0]  idx;
    logic        slot_end;
    logic        frame_end;

    logic [15:0] act_data;
    logic [3:0]  act_dp;
    logic [15:0] pend_data;
    logic [3:0]  pend_dp;
    logic        pend_valid;

    logic [3:0]  nib;
    logic [6:0]  glyph;
    logic [3:0]  ssegd_nxt;
    logic [7:0]  sseg_nxt;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 2'd3);
    assign nib       = act_data[{idx, 2'b00} +: 4];

    // Active-low hex glyphs, bit order g..a
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    logic lead_zero;

    // A digit goes dark when it and every more significant nibble are zero; digit 0 always shows
    always_comb begin
        lead_zero = 1'b0;
        case (idx)
            2'd3:    lead_zero = (act_data[15:12] == 4'h0);
            2'd2:    lead_zero = (act_data[15:8] == 8'h00);
            2'd1:    lead_zero = (act_data[15:4] == 12'h000);
            default: lead_zero = 1'b0;
        endcase
    end

    assign glyph = lead_zero ? 7'h7F : hex7(nib);
`else
    assign glyph = hex7(nib);
`endif

    // Slot phase state register
    always_ff @(posedge M_CLOCK) begin
        if (RESET) begin
            state <= ST_GUARD;
        end else begin
            state <= state_nxt;
        end
    end

    // Guard ends after GUARD_CYCLES counts; the slot always closes back into guard
    always_comb begin
        state_nxt = state;
        if (slot_end) begin
            state_nxt = ST_GUARD;
        end else if (state == ST_GUARD && cnt == GUARD_LAST) begin
            state_nxt = ST_DRIVE;
        end
    end

    // Slot counter and digit index advance
    always_ff @(posedge M_CLOCK) begin
        if (RESET) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Loads park in pending and only reach the display at a frame boundary
    always_ff @(posedge M_CLOCK) begin
        if (RESET) begin
            act_data   <= '0;
            act_dp     <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else if (frame_end) begin
            if (LOAD) begin
                act_data <= DATA;
                act_dp   <= DP_IN;
            end else if (pend_valid) begin
                act_data <= pend_data;
                act_dp   <= pend_dp;
            end
            pend_valid <= 1'b0;
        end else if (LOAD) begin
            pend_data  <= DATA;
            pend_dp    <= DP_IN;
            pend_valid <= 1'b1;
        end
    end

    // Next output values: everything dark in guard, one digit lit in drive unless blanked
    always_comb begin
        ssegd_nxt = 4'hF;
        sseg_nxt  = 8'hFF;
        if (state == ST_DRIVE) begin
            ssegd_nxt = ~(4'b0001 << idx);
            if (!BLANK[idx]) begin
                sseg_nxt = {~act_dp[idx], glyph};
            end
        end
    end

    // Registered outputs so the pins never glitch on decode
    always_ff @(posedge M_CLOCK) begin
        if (RESET) begin
            IO_SSEGD   <= 4'hF;
            IO_SSEG    <= 8'hFF;
            FRAME_DONE <= 1'b0;
        end else begin
            IO_SSEGD   <= ssegd_nxt;
            IO_SSEG    <= sseg_nxt;
            FRAME_DONE <= frame_end;
        end
    end

    assign IO_SSEG_COL = 1'b1;

endmodule
